// File: rtl/mem_port_arbiter_if.sv
// Purpose: bundle of the two cache-side line ports and the shared memory-side port.
// Latency: n/a (wires only).
// Backpressure: rN_busywait_o holds a requester; m_busywait_i holds the arbiter.
// Modports: master = arbiter view (takes requests, drives memory command);
//           slave  = environment view (caches drive requests, memory answers).
interface mem_port_arbiter_if #(
  parameter int address_size = 32,
  parameter int c_line_size  = 32,
  parameter int c_block_size = 2
);
  localparam int LW = (2**c_block_size) * c_line_size;
  localparam int AW = address_size - c_block_size - 2;

  // cache port 0 (instruction cache)
  logic          r0_read_i;
  logic          r0_wr_i;
  logic [AW-1:0] r0_address_i;
  logic [LW-1:0] r0_write_data_i;
  logic          r0_busywait_o;
  logic [LW-1:0] r0_read_data_o;
  logic          r0_read_done_o;
  logic          r0_write_done_o;

  // cache port 1 (data cache)
  logic          r1_read_i;
  logic          r1_wr_i;
  logic [AW-1:0] r1_address_i;
  logic [LW-1:0] r1_write_data_i;
  logic          r1_busywait_o;
  logic [LW-1:0] r1_read_data_o;
  logic          r1_read_done_o;
  logic          r1_write_done_o;

  // shared memory port
  logic          m_read_o;
  logic          m_wr_o;
  logic [AW-1:0] m_address_o;
  logic [LW-1:0] m_write_data_o;
  logic [LW-1:0] m_read_data_i;
  logic          m_busywait_i;
  logic          m_read_done_i;
  logic          m_write_done_i;

  logic          err_timeout_o;

  modport master (
    input  r0_read_i, r0_wr_i, r0_address_i, r0_write_data_i,
    output r0_busywait_o, r0_read_data_o, r0_read_done_o, r0_write_done_o,
    input  r1_read_i, r1_wr_i, r1_address_i, r1_write_data_i,
    output r1_busywait_o, r1_read_data_o, r1_read_done_o, r1_write_done_o,
    output m_read_o, m_wr_o, m_address_o, m_write_data_o,
    input  m_read_data_i, m_busywait_i, m_read_done_i, m_write_done_i,
    output err_timeout_o
  );

  modport slave (
    output r0_read_i, r0_wr_i, r0_address_i, r0_write_data_i,
    input  r0_busywait_o, r0_read_data_o, r0_read_done_o, r0_write_done_o,
    output r1_read_i, r1_wr_i, r1_address_i, r1_write_data_i,
    input  r1_busywait_o, r1_read_data_o, r1_read_done_o, r1_write_done_o,
    input  m_read_o, m_wr_o, m_address_o, m_write_data_o,
    output m_read_data_i, m_busywait_i, m_read_done_i, m_write_done_i,
    input  err_timeout_o
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Purpose: round-robin arbiter sharing one line-wide memory port between I$ (port 0) and D$ (port 1).
// Latency: command on memory 1 cycle after request sampled in IDLE; done is combinational with memory completion.
// Backpressure: non-granted requester sees busywait; granted one until completion; 8-bit watchdog releases a hung grant.
// Ports: clk_i, reset_i (async, active-high); bus = mem_port_arbiter_if.master carrying
//        both cache ports (read/wr/address/write_data in, busywait/read_data/done out),
//        the memory port (command out, read_data/busywait/done in) and err_timeout_o.
module mem_port_arbiter #(
  parameter int address_size = 32,
  parameter int c_line_size  = 32,
  parameter int c_block_size = 2,
  parameter int c_timeout    = 255
) (
  input  logic             clk_i,
  input  logic             reset_i,
  mem_port_arbiter_if.master bus
);
  localparam int LW = (2**c_block_size) * c_line_size;
  localparam int AW = address_size - c_block_size - 2;
  localparam logic [7:0] WD_LIMIT = 8'(c_timeout);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GRANT0  = 2'd1,
    S_GRANT1  = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic          r_last;
  logic [7:0]    r_wd;
  logic          r_err;

  logic          w_req0;
  logic          w_req1;
  logic          w_gnt0;
  logic          w_gnt1;
  logic          w_sel_wr;
  logic          w_complete;
  logic          w_timeout;

  logic          w_m_read;
  logic          w_m_wr;
  logic [AW-1:0] w_m_address;
  logic [LW-1:0] w_m_write_data;
  logic          w_r0_read_done;
  logic          w_r0_write_done;
  logic          w_r1_read_done;
  logic          w_r1_write_done;

  assign w_req0 = bus.r0_read_i | bus.r0_wr_i;
  assign w_req1 = bus.r1_read_i | bus.r1_wr_i;
  assign w_gnt0 = (r_state == S_GRANT0);
  assign w_gnt1 = (r_state == S_GRANT1);

  // A write wins over a simultaneous read on the same port.
  assign w_sel_wr   = (w_gnt0 & bus.r0_wr_i) | (w_gnt1 & bus.r1_wr_i);
  assign w_complete = (w_gnt0 | w_gnt1) & ~bus.m_busywait_i &
                      (w_sel_wr ? bus.m_write_done_i : bus.m_read_done_i);
  // Completion in the limit cycle still counts as a normal completion.
  assign w_timeout  = (w_gnt0 | w_gnt1) & ~w_complete & (r_wd == WD_LIMIT);

  // State register plus arbitration bookkeeping.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state <= S_IDLE;
      r_last  <= 1'b1;   // port 0 wins the first tie
      r_wd    <= 8'd0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && w_next == S_GRANT0) begin
        r_last <= 1'b0;
        r_wd   <= 8'd0;
      end else if (r_state == S_IDLE && w_next == S_GRANT1) begin
        r_last <= 1'b1;
        r_wd   <= 8'd0;
      end else if ((w_gnt0 | w_gnt1) && !w_complete && !w_timeout) begin
        r_wd <= r_wd + 8'd1;
      end
      if (w_timeout) begin
        r_err <= 1'b1;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_req0 && w_req1) begin
          w_next = r_last ? S_GRANT0 : S_GRANT1;
        end else if (w_req0) begin
          w_next = S_GRANT0;
        end else if (w_req1) begin
          w_next = S_GRANT1;
        end
      end
      S_GRANT0, S_GRANT1: begin
        if (w_complete || w_timeout) begin
          w_next = S_RELEASE;
        end
      end
      S_RELEASE: w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // Output logic: memory port is a pure mux of the granted port, zero otherwise.
  always_comb begin
    w_m_read        = 1'b0;
    w_m_wr          = 1'b0;
    w_m_address     = '0;
    w_m_write_data  = '0;
    w_r0_read_done  = 1'b0;
    w_r0_write_done = 1'b0;
    w_r1_read_done  = 1'b0;
    w_r1_write_done = 1'b0;
    case (r_state)
      S_GRANT0: begin
        w_m_read        = bus.r0_read_i & ~bus.r0_wr_i;
        w_m_wr          = bus.r0_wr_i;
        w_m_address     = bus.r0_address_i;
        w_m_write_data  = bus.r0_write_data_i;
        w_r0_read_done  = w_complete & ~w_sel_wr;
        w_r0_write_done = w_complete & w_sel_wr;
      end
      S_GRANT1: begin
        w_m_read        = bus.r1_read_i & ~bus.r1_wr_i;
        w_m_wr          = bus.r1_wr_i;
        w_m_address     = bus.r1_address_i;
        w_m_write_data  = bus.r1_write_data_i;
        w_r1_read_done  = w_complete & ~w_sel_wr;
        w_r1_write_done = w_complete & w_sel_wr;
      end
      default: ;
    endcase
  end

  assign bus.m_read_o        = w_m_read;
  assign bus.m_wr_o          = w_m_wr;
  assign bus.m_address_o     = w_m_address;
  assign bus.m_write_data_o  = w_m_write_data;

  assign bus.r0_read_done_o  = w_r0_read_done;
  assign bus.r0_write_done_o = w_r0_write_done;
  assign bus.r1_read_done_o  = w_r1_read_done;
  assign bus.r1_write_done_o = w_r1_write_done;

  assign bus.r0_busywait_o   = w_req0 & ~(w_gnt0 & w_complete);
  assign bus.r1_busywait_o   = w_req1 & ~(w_gnt1 & w_complete);

  assign bus.r0_read_data_o  = bus.m_read_data_i;
  assign bus.r1_read_data_o  = bus.m_read_data_i;

  assign bus.err_timeout_o   = r_err;
endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
  localparam int LW = 128;
  localparam int AW = 28;
  localparam logic [LW-1:0] PAT_A5 = {16{8'hA5}};
  localparam logic [LW-1:0] PAT_DB = {4{32'hDEADBEEF}};

  logic clk_i = 1'b0;
  logic reset_i;
  int   checks = 0;
  int   failures = 0;

  mem_port_arbiter_if #(.address_size(32), .c_line_size(32), .c_block_size(2)) bus ();

  mem_port_arbiter #(
    .address_size(32), .c_line_size(32), .c_block_size(2), .c_timeout(255)
  ) dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .bus     (bus)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int n;
    logic saw_done;
    logic err_in_grant;
    logic [AW-1:0] exp_addr;

    reset_i = 1'b1;
    bus.r0_read_i = 0; bus.r0_wr_i = 0; bus.r0_address_i = '0; bus.r0_write_data_i = '0;
    bus.r1_read_i = 0; bus.r1_wr_i = 0; bus.r1_address_i = '0; bus.r1_write_data_i = '0;
    bus.m_read_data_i = '0; bus.m_busywait_i = 0; bus.m_read_done_i = 0; bus.m_write_done_i = 0;

    // Reset state
    repeat (2) @(negedge clk_i);
    #1;
    chk("rst_m_read", bus.m_read_o, 0);
    chk("rst_m_wr", bus.m_wr_o, 0);
    chk("rst_err", bus.err_timeout_o, 0);
    chk("rst_bw0", bus.r0_busywait_o, 0);

    // Port 0 read, then async reset in the middle of GRANT0
    @(negedge clk_i);
    reset_i = 1'b0;
    bus.r0_read_i = 1; bus.r0_address_i = 28'h0000456;
    #1;
    chk("idle_bw0", bus.r0_busywait_o, 1);
    chk("idle_no_cmd", bus.m_read_o, 0);
    @(negedge clk_i); #1;
    chk("g0_cmd", bus.m_read_o, 1);
    chk("g0_addr", bus.m_address_o, 28'h0000456);
    #1 reset_i = 1'b1;
    #1;
    chk("arst_m_read", bus.m_read_o, 0);
    chk("arst_m_addr", bus.m_address_o, 0);
    chk("arst_bw0", bus.r0_busywait_o, 1);
    chk("arst_err", bus.err_timeout_o, 0);

    // After reset both ports request: port 0 must win the tie
    @(negedge clk_i);
    reset_i = 1'b0;
    bus.r0_address_i = 28'h0000123;
    bus.r1_read_i = 1; bus.r1_address_i = 28'h0ABCDEF;
    bus.m_read_data_i = PAT_A5;
    #1;
    chk("post_rst_idle", bus.m_read_o, 0);
    @(negedge clk_i); #1;
    chk("post_rst_cmd", bus.m_read_o, 1);
    chk("post_rst_addr", bus.m_address_o, 28'h0000123);
    chk("post_rst_bw1", bus.r1_busywait_o, 1);
    bus.m_read_done_i = 1;
    #1;
    chk("p0_rd_done", bus.r0_read_done_o, 1);
    chk("p0_bw_low", bus.r0_busywait_o, 0);
    chk("p1_no_done", bus.r1_read_done_o, 0);
    @(negedge clk_i);
    bus.m_read_done_i = 0; bus.r0_read_i = 0;
    #1;
    chk("p0_release", bus.m_read_o, 0);
    chk("p0_release_bw1", bus.r1_busywait_o, 1);
    @(negedge clk_i); #1;
    chk("p0_idle", bus.m_read_o, 0);

    // Port 1 read, memory completes on the 5th grant cycle
    @(negedge clk_i);
    bus.m_busywait_i = 1;
    #1;
    chk("p1_cmd", bus.m_read_o, 1);
    chk("p1_addr", bus.m_address_o, 28'h0ABCDEF);
    chk("p1_c1_no_done", bus.r1_read_done_o, 0);
    repeat (3) @(negedge clk_i);
    bus.m_read_done_i = 1;  // memory still busy: must not complete
    #1;
    chk("p1_busy_gates_done", bus.r1_read_done_o, 0);
    chk("p1_busy_bw", bus.r1_busywait_o, 1);
    @(negedge clk_i);
    bus.m_busywait_i = 0;
    #1;
    chk("p1_rd_done", bus.r1_read_done_o, 1);
    chk("p1_rd_data", bus.r1_read_data_o, PAT_A5);
    chk("p1_bw_low", bus.r1_busywait_o, 0);
    chk("p1_p0_no_done", bus.r0_read_done_o, 0);
    @(negedge clk_i);
    bus.m_read_done_i = 0; bus.r1_read_i = 0;
    #1;
    chk("p1_release", bus.m_read_o, 0);
    chk("p1_release_no_done", bus.r1_read_done_o, 0);
    @(negedge clk_i); #1;
    chk("p1_idle", bus.m_read_o, 0);

    // Both ports request continuously: grants alternate 0,1,0,1
    @(negedge clk_i);
    bus.r0_read_i = 1; bus.r0_address_i = 28'h0000100;
    bus.r1_read_i = 1; bus.r1_address_i = 28'h0000200;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i); #1;
      exp_addr = (i % 2 == 1) ? 28'h0000200 : 28'h0000100;
      chk("rr_addr", bus.m_address_o, exp_addr);
      chk("rr_cmd", bus.m_read_o, 1);
      chk("rr_other_bw", (i % 2 == 1) ? bus.r0_busywait_o : bus.r1_busywait_o, 1);
      bus.m_read_done_i = 1;
      #1;
      chk("rr_done", (i % 2 == 1) ? bus.r1_read_done_o : bus.r0_read_done_o, 1);
      chk("rr_other_no_done", (i % 2 == 1) ? bus.r0_read_done_o : bus.r1_read_done_o, 0);
      @(negedge clk_i);
      bus.m_read_done_i = 0;
      if (i == 3) begin
        bus.r0_read_i = 0; bus.r1_read_i = 0;
      end
      #1;
      chk("rr_release", bus.m_read_o, 0);
      @(negedge clk_i); #1;
      chk("rr_idle", bus.m_read_o, 0);
    end

    // Port 0 read+wr: write is served, read_done ignored
    @(negedge clk_i);
    bus.r0_read_i = 1; bus.r0_wr_i = 1; bus.r0_write_data_i = PAT_DB;
    @(negedge clk_i); #1;
    chk("wr_m_wr", bus.m_wr_o, 1);
    chk("wr_m_read", bus.m_read_o, 0);
    chk("wr_data", bus.m_write_data_o, PAT_DB);
    bus.m_read_done_i = 1;
    #1;
    chk("wr_rd_done_ignored", bus.r0_write_done_o, 0);
    chk("wr_no_rd_done", bus.r0_read_done_o, 0);
    chk("wr_bw_held", bus.r0_busywait_o, 1);
    @(negedge clk_i);
    bus.m_read_done_i = 0; bus.m_write_done_i = 1;
    #1;
    chk("wr_still_granted", bus.m_wr_o, 1);
    chk("wr_done", bus.r0_write_done_o, 1);
    chk("wr_bw_low", bus.r0_busywait_o, 0);
    chk("wr_no_rd_done2", bus.r0_read_done_o, 0);
    @(negedge clk_i);
    bus.m_write_done_i = 0; bus.r0_read_i = 0; bus.r0_wr_i = 0;
    #1;
    chk("wr_release", bus.m_wr_o, 0);

    // Stray memory done pulses in IDLE
    @(negedge clk_i);
    bus.m_read_done_i = 1; bus.m_write_done_i = 1;
    #1;
    chk("stray_r0_rd", bus.r0_read_done_o, 0);
    chk("stray_r1_rd", bus.r1_read_done_o, 0);
    chk("stray_r0_wr", bus.r0_write_done_o, 0);
    @(negedge clk_i); #1;
    chk("stray_no_cmd_rd", bus.m_read_o, 0);
    chk("stray_no_cmd_wr", bus.m_wr_o, 0);
    bus.m_read_done_i = 0; bus.m_write_done_i = 0;

    // Watchdog: memory never completes
    @(negedge clk_i);
    bus.r1_read_i = 1; bus.r1_address_i = 28'h0FFFFFF; bus.m_busywait_i = 1;
    n = 0; saw_done = 0; err_in_grant = 0;
    @(negedge clk_i); #1;
    while (bus.m_read_o && n < 400) begin
      n++;
      if (bus.r1_read_done_o) saw_done = 1;
      err_in_grant = bus.err_timeout_o;
      @(negedge clk_i); #1;
    end
    chk("wd_grant_cycles", n, 256);
    chk("wd_no_done", saw_done, 0);
    chk("wd_err_during_grant", err_in_grant, 0);
    chk("wd_err_set", bus.err_timeout_o, 1);
    chk("wd_release_bw1", bus.r1_busywait_o, 1);
    @(negedge clk_i); #1;
    chk("wd_idle", bus.m_read_o, 0);
    chk("wd_err_sticky", bus.err_timeout_o, 1);
    @(negedge clk_i); #1;
    chk("wd_regrant", bus.m_read_o, 1);
    chk("wd_regrant_addr", bus.m_address_o, 28'h0FFFFFF);
    bus.m_busywait_i = 0; bus.m_read_done_i = 1;
    #1;
    chk("wd_regrant_done", bus.r1_read_done_o, 1);
    @(negedge clk_i);
    bus.m_read_done_i = 0; bus.r1_read_i = 0;
    #1;
    chk("wd_err_sticky2", bus.err_timeout_o, 1);
    reset_i = 1'b1;
    #1;
    chk("wd_err_cleared", bus.err_timeout_o, 0);
    @(negedge clk_i);
    reset_i = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-port arbiter that shares the single cache-line-wide data-memory port between two cache controllers (port 0: instruction cache, port 1: data cache). It grants whole line transactions (one refill read or one write-back) in round-robin order and holds the grant until the memory signals completion or a watchdog expires. It sits between the caches' memory-side interfaces and the data memory, so neither cache needs changes.

## Interface
- `address_size`, default 32: byte address width.
- `c_line_size`, default 32: word width in bits.
- `c_block_size`, default 2: log2 of words per line. Line width LW = 2**c_block_size*c_line_size = 128.
- Line address width: AW = address_size-c_block_size-2 = 28.
- `c_timeout`, default 255: maximum cycles a grant may wait for completion. The counter is 8 bits wide.
- `clk_i`, in, 1: clock. All state updates on posedge.
- `reset_i`, in, 1: asynchronous, active-high reset.
- `r0_read_i`, `r1_read_i`, in, 1: line read (refill) request, level.
- `r0_wr_i`, `r1_wr_i`, in, 1: line write (write-back) request, level.
- `r0_address_i`, `r1_address_i`, in, AW: line address.
- `r0_write_data_i`, `r1_write_data_i`, in, LW: write-back line.
- `r0_busywait_o`, `r1_busywait_o`, out, 1: requester must hold its request.
- `r0_read_data_o`, `r1_read_data_o`, out, LW: refill line. Driven by `m_read_data_i` to both ports.
- `r0_read_done_o`, `r1_read_done_o`, `r0_write_done_o`, `r1_write_done_o`, out, 1: completion pulses.
- `m_read_o`, `m_wr_o`, out, 1: memory command.
- `m_address_o`, out, AW; `m_write_data_o`, out, LW: memory address and write data.
- `m_read_data_i`, in, LW; `m_busywait_i`, `m_read_done_i`, `m_write_done_i`, in, 1: memory response.
- `err_timeout_o`, out, 1: sticky watchdog flag.

## Operation
- Request definition: reqN = rN_read_i | rN_wr_i.
  - If a port asserts both read and write, the write is served. m_read_o is read & !wr.
- States: IDLE, GRANT0, GRANT1, RELEASE. Registers: `last` (last granted port), 8-bit `wd` counter, `err`.
- IDLE: no memory command is driven; m_* outputs are 0.
  - If only one request is active, go to that port's GRANT state.
  - If both are active, go to GRANT of the port != `last`.
  - When entering GRANTn, set `last` = n and clear `wd` to 0.
- GRANTn: the memory command, address and write data are driven combinationally from port n.
  - Completion = !m_busywait_i & (wr ? m_write_done_i : m_read_done_i).
  - On completion, pulse rn_read_done_o or rn_write_done_o (same cycle, combinational) and go to RELEASE.
  - If `wd` == c_timeout without completion: set `err`, go to RELEASE, no done pulse.
  - Otherwise increment `wd`.
  - The grant is never revoked early. Request changes at port n during GRANTn are forwarded as driven; requesters must hold until done.
- RELEASE: one cycle with all m_* outputs 0, so the memory sees the command drop. Then go to IDLE.
- rN_busywait_o = reqN & !(state==GRANTn & completion). The non-granted port sees busywait whenever it requests.
- Done outputs are 0 outside GRANTn for port n. Memory done pulses arriving in IDLE or RELEASE are ignored.
- Reset (asynchronous, any state, including mid-transaction):
  - state=IDLE, `last`=1 (port 0 wins the first tie), `wd`=0, err_timeout_o=0.
  - m_read_o, m_wr_o, m_address_o and m_write_data_o are 0.
  - All done outputs are 0; busywait outputs equal reqN.
  - The in-flight memory transaction is abandoned.

## Timing
- Arbitration latency: a request sampled at posedge T (state IDLE) drives the memory command from cycle T+1.
- Completion in cycle C: done pulse and busywait low in C; RELEASE in C+1; IDLE in C+2.
- The earliest next grant drives the memory command in C+3.
- Back-to-back requests alternate ports: the minimum gap between transactions is 2 idle cycles (RELEASE, IDLE).
- Watchdog: the timeout fires in the cycle where `wd`==c_timeout, i.e. the (c_timeout+1)th GRANT cycle. RELEASE follows.
- `err` sets at the edge leaving GRANT and holds until reset_i.

## Test plan
- Reset mid-GRANT0: assert reset_i asynchronously → state IDLE immediately; m_read_o=m_wr_o=0; err_timeout_o=0. After release, a port-0 read with addr 0x0000123 → m_address_o=0x0000123 at T+1.
- Single read, port 1: memory done after 5 cycles, data 0xA5…A5 → r1_read_done_o pulses 1 cycle with r1_read_data_o=0xA5…A5. r1_busywait_o low that cycle. m_read_o low for 1 cycle (RELEASE) afterwards.
- Simultaneous requests, both ports for 4 transactions: grants alternate 0,1,0,1. Non-granted busywait stays high throughout. No memory command overlaps.
- Port 0 asserts read+wr, data 0xDEAD…BEEF: m_wr_o=1, m_read_o=0, m_write_data_o=0xDEAD…BEEF. Completes only on m_write_done_i; m_read_done_i alone is ignored.
- Memory never completes, c_timeout=255: RELEASE after 256 GRANT cycles; err_timeout_o=1 and sticky. No done pulse. The still-requesting port is regranted next by round-robin.
- Stray done pulses: m_read_done_i pulses in IDLE → no rN done outputs and no state change.
